// File: rtl/ir_pipeline_regs.sv
// ============================================================================
// Module   : ir_pipeline_regs
// Purpose  : Fetch PC, PC1-PC3 / IR1-IR4 pipeline registers with stall bubbles,
//            branch flush of stages 1-2, sticky STOP halt and a cycle counter.
//            Optional STALL_STATS_EN adds a saturating StallCount output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ir_pipeline_regs #(
    parameter int             W         = 8,
    parameter logic [W-1:0]   NOP_INSTR = W'(8'h0A),
    parameter logic [3:0]     STOP_OP   = 4'b0001,
    parameter int             CNT_W     = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              PCWrite,
    input  logic              PC1_Load,
    input  logic              PC2_Load,
    input  logic              PC3_Load,
    input  logic              IR_1_Load,
    input  logic              IR_2_Load,
    input  logic              IR_3_Load,
    input  logic              IR_4_Load,
    input  logic              CounterOn,
    input  logic              Flush,
    input  logic [W-1:0]      BranchTarget,
    input  logic [W-1:0]      MemInstr,
    output logic [W-1:0]      PC,
    output logic [W-1:0]      PC1,
    output logic [W-1:0]      PC2,
    output logic [W-1:0]      PC3,
    output logic [W-1:0]      IR1,
    output logic [W-1:0]      IR2,
    output logic [W-1:0]      IR3,
    output logic [W-1:0]      IR4,
    output logic              Valid1,
    output logic              Valid2,
    output logic              Valid3,
    output logic              Valid4,
    output logic              Halted,
    output logic [CNT_W-1:0]  Counter
`ifdef STALL_STATS_EN
    ,
    output logic [CNT_W-1:0]  StallCount
`endif
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    logic [W-1:0]      r_pc;
    logic [W-1:0]      r_pc1;
    logic [W-1:0]      r_pc2;
    logic [W-1:0]      r_pc3;
    logic [W-1:0]      r_ir [0:3];
    logic [3:0]        r_vld;
    logic              r_halted;
    logic [CNT_W-1:0]  r_cnt;

    logic [3:0]        w_ir_ld;
    logic              w_stop_load;

    assign w_ir_ld     = {IR_4_Load, IR_3_Load, IR_2_Load, IR_1_Load};
    // IR4 receives a real STOP only when IR3 is shifted in (not a bubble) and is valid
    assign w_stop_load = IR_4_Load && IR_3_Load && r_vld[2] && (r_ir[2][3:0] == STOP_OP);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc  <= '0;
            r_pc1 <= '0;
            r_pc2 <= '0;
            r_pc3 <= '0;
        end else begin
            if (Flush) begin
                r_pc <= BranchTarget;
            end else if (PCWrite) begin
                r_pc <= r_pc + W'(1);
            end
            if (PC1_Load) r_pc1 <= r_pc;
            if (PC2_Load) r_pc2 <= r_pc1;
            if (PC3_Load) r_pc3 <= r_pc2;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) begin
                r_ir[k] <= NOP_INSTR;
            end
            r_vld <= '0;
        end else begin
            if (Flush) begin
                r_ir[0]  <= NOP_INSTR;
                r_vld[0] <= 1'b0;
            end else if (w_ir_ld[0]) begin
                r_ir[0]  <= MemInstr;
                r_vld[0] <= 1'b1;
            end
            // A loading stage whose upstream is holding takes a bubble, never a copy
            for (int k = 1; k < 4; k++) begin
                if (Flush && k == 1) begin
                    r_ir[k]  <= NOP_INSTR;
                    r_vld[k] <= 1'b0;
                end else if (w_ir_ld[k]) begin
                    if (w_ir_ld[k-1]) begin
                        r_ir[k]  <= r_ir[k-1];
                        r_vld[k] <= r_vld[k-1];
                    end else begin
                        r_ir[k]  <= NOP_INSTR;
                        r_vld[k] <= 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_halted <= 1'b0;
            r_cnt    <= '0;
        end else begin
            if (w_stop_load) begin
                r_halted <= 1'b1;
            end
            if (CounterOn && !r_halted && (r_cnt != C_CNT_MAX)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

`ifdef STALL_STATS_EN
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (!PCWrite && !Flush && !r_halted && (r_stall_cnt != C_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign StallCount = r_stall_cnt;
`endif

    assign PC      = r_pc;
    assign PC1     = r_pc1;
    assign PC2     = r_pc2;
    assign PC3     = r_pc3;
    assign IR1     = r_ir[0];
    assign IR2     = r_ir[1];
    assign IR3     = r_ir[2];
    assign IR4     = r_ir[3];
    assign Valid1  = r_vld[0];
    assign Valid2  = r_vld[1];
    assign Valid3  = r_vld[2];
    assign Valid4  = r_vld[3];
    assign Halted  = r_halted;
    assign Counter = r_cnt;

endmodule

`default_nettype wire

// File: doc/ir_pipeline_regs.md
Name: ir_pipeline_regs

Overview:
- Datapath-side consumer of the pipeline load/stall controls: PCWrite, PC1_Load..PC3_Load, IR_1_Load..IR_4_Load and CounterOn.
- Holds the fetch PC, the PC1-PC3 and IR1-IR4 pipeline registers, the per-stage valid bits and the cycle counter.
- Inserts NOP bubbles on stalls and flushes stages 1-2 on a taken branch.
- Feeds IR1's opcode back to the stall-control decode and all stage registers to the downstream datapath.

Parameters:
- W, 8, instruction and PC width.
- NOP_INSTR, 8'h0A, bubble encoding; opcode field is bits [3:0].
- STOP_OP, 4'b0001, opcode that halts the machine.
- CNT_W, 16, cycle-counter width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- PCWrite  in  1  advance PC.
- PC1_Load, PC2_Load, PC3_Load  in  1 each  PC stage load enables.
- IR_1_Load, IR_2_Load, IR_3_Load, IR_4_Load  in  1 each  IR stage load enables.
- CounterOn  in  1  cycle counter enable.
- Flush  in  1  taken branch; redirect and squash stages 1-2.
- BranchTarget  in  W  redirect address.
- MemInstr  in  W  instruction memory read data at address PC.
- PC  out  W  fetch address.
- PC1, PC2, PC3  out  W each  stage PCs.
- IR1, IR2, IR3, IR4  out  W each  stage instructions.
- Valid1..Valid4  out  1 each  stage holds a real instruction.
- Halted  out  1  sticky stop indicator.
- Counter  out  CNT_W  executed-cycle count.

Behaviour:
- Single clock domain. Every register updates on the rising edge of clock.
- Reset (synchronous, active-high):
  - PC, PC1-PC3 and Counter = 0.
  - IR1-IR4 = NOP_INSTR.
  - Valid1-4 = 0. Halted = 0.
  - Reset mid-operation discards all in-flight state the following edge.
- PC:
  - Flush=1: PC <= BranchTarget. Flush has priority over PCWrite.
  - Else PCWrite=1: PC <= PC+1, wrapping mod 2^W (8'hFF -> 8'h00).
  - Else PC holds.
- Stage 1:
  - IR_1_Load=1: IR1 <= MemInstr, Valid1 <= 1.
  - PC1_Load=1: PC1 <= PC.
  - Otherwise each holds.
- Stages k = 2..4:
  - IR_k_Load=1 and IR_(k-1)_Load=1: IR_k <= IR_(k-1), Valid_k <= Valid_(k-1).
  - IR_k_Load=1 and IR_(k-1)_Load=0: bubble, IR_k <= NOP_INSTR, Valid_k <= 0. This prevents duplicating the held instruction.
  - IR_k_Load=0: hold.
  - PC_k (k=2,3) <= PC_(k-1) when PCk_Load=1, else hold. PC values carry no bubble rule.
- Flush=1:
  - Next cycle IR1 = IR2 = NOP_INSTR and Valid1 = Valid2 = 0, regardless of load enables.
  - IR3 is loaded from the pre-flush IR2 under the normal stage rule.
  - Stage 4 follows normal rules.
- Halted:
  - Set on the edge where IR4 is loaded with a valid instruction whose opcode equals STOP_OP.
  - Stays 1 until reset.
  - While Halted=1, Counter freezes.
  - Other pipeline registers still obey their inputs; the stall control is responsible for deasserting the loads.
- Counter:
  - Increments by 1 on each edge with CounterOn=1 and Halted=0.
  - Saturates at all-ones; no wrap.
- Latency: an instruction fetched at edge n appears in IR4 at edge n+3 with no stalls.
- Simultaneous reset and Flush: reset wins.

Optional Feature:
- Macro STALL_STATS_EN.
- Defined:
  - Adds output port StallCount [CNT_W-1:0], reset to 0.
  - Increments on each edge with PCWrite=0, Flush=0 and Halted=0.
  - Saturates at all-ones.
- Undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- Reset, then all loads=1 with MemInstr = 8'h11, 8'h22, 8'h33, 8'h44 on successive cycles -> IR4 = 8'h11 with Valid4=1 on the 4th edge; PC = 4; Counter = 4.
- Single stall: IR_1_Load = PC1_Load = PCWrite = 0 for one cycle, other loads 1 -> IR2 = 8'h0A with Valid2=0 next cycle; IR1 and PC hold; no instruction duplicated in IR3 or IR4.
- Flush with BranchTarget = 8'h40 while IR1 = 8'h22 and IR2 = 8'h11 -> next cycle PC = 8'h40, IR1 = IR2 = 8'h0A, Valid1 = Valid2 = 0, IR3 = 8'h11; Flush together with PCWrite=1 still yields PC = 8'h40.
- STOP: feed 8'h01 -> 3 edges later IR4 = 8'h01 and Halted=1; Counter holds its value for the next 10 cycles with CounterOn=1. Feeding 8'h01 as a bubbled (Valid=0) slot does not set Halted.
- Boundaries: PC = 8'hFF with PCWrite=1 -> 8'h00. Preload Counter near saturation (CNT_W=4 build) -> stops at 4'hF. Assert reset mid-stream -> all outputs return to reset values next edge.
- STALL_STATS_EN build: 5 cycles with PCWrite=0 (no flush, not halted) -> StallCount = 5. Non-macro build compiles without the StallCount port.
